program_loader: RTL and testbench

- Writer side of the instruction memory's debug write port (wr_instruction / data_instruction / address).
- Receives a byte stream from the debug UART receiver and packs every 4 bytes, MSB first, into one 32-bit instruction.
- Writes each packed instruction into instruction memory at consecutive word addresses starting at 0.
- Loading stops on a halt instruction or when memory is full. The block then reports completion to the debug unit controller.

---
 rtl/program_loader.sv | 121 ++++++++++++
 tb/tb_program_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: packs debug-UART bytes MSB-first into 32-bit words and writes them to instruction memory
module program_loader #(
    parameter int          MEM_DEPTH      = 32,
    parameter int          ADDR_W         = 5,
    parameter logic [31:0] HALT_WORD      = 32'hFC000000,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter int          TO_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_instruction,
    output logic [31:0]       data_instruction,
    output logic [31:0]       inst_addr,
    output logic              busy,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              timeout_err
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t            state_q;
    logic [31:0]       word_q;
    logic [31:0]       data_q;
    logic [1:0]        byte_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              wr_q;
    logic              busy_q;
    logic              done_q;
    logic              to_err_q;

    logic [31:0] word_d;
    logic        last_w;
    logic        to_hit;

    assign word_d = {word_q[23:0], rx_data};
    assign last_w = (data_q == HALT_WORD) || (addr_q == ADDR_W'(MEM_DEPTH - 1));
    assign to_hit = to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1);

    assign wr_instruction   = wr_q;
    assign data_instruction = data_q;
    assign inst_addr        = {{(32 - ADDR_W){1'b0}}, addr_q};
    assign busy             = busy_q;
    assign load_done        = done_q;
    assign word_count       = count_q;
    assign timeout_err      = to_err_q;

    // Load FSM: byte packing, one-cycle write strobe, halt/full termination and inter-byte timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            data_q     <= '0;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            to_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= RECV;
                        addr_q     <= '0;
                        byte_cnt_q <= '0;
                        to_cnt_q   <= '0;
                        count_q    <= '0;
                        to_err_q   <= 1'b0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                RECV: begin
                    if (rx_valid) begin
                        word_q     <= word_d;
                        to_cnt_q   <= '0;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            data_q  <= word_d;
                            wr_q    <= 1'b1;
                            state_q <= WRITE;
                        end
                    end else if (byte_cnt_q == 2'd0) begin
                        to_cnt_q <= '0;
                    end else if (to_hit) begin
                        word_q     <= '0;
                        byte_cnt_q <= '0;
                        to_cnt_q   <= '0;
                        to_err_q   <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                WRITE: begin
                    wr_q    <= 1'b0;
                    count_q <= count_q + (ADDR_W + 1)'(1);
                    if (last_w) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RECV;
                        addr_q  <= addr_q + ADDR_W'(1);
                        if (rx_valid) begin
                            word_q     <= word_d;
                            byte_cnt_q <= 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader with a shortened inter-byte timeout
module tb_program_loader;
    localparam int TO = 40;
    localparam logic [31:0] HALT = 32'hFC000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        wr_instruction;
    logic [31:0] data_instruction;
    logic [31:0] inst_addr;
    logic        busy;
    logic        load_done;
    logic [5:0]  word_count;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];
    logic prev_wr = 1'b0;

    program_loader #(
        .MEM_DEPTH(32), .ADDR_W(5), .HALT_WORD(HALT), .TIMEOUT_CYCLES(TO), .TO_W(6)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_instruction(wr_instruction), .data_instruction(data_instruction),
        .inst_addr(inst_addr), .busy(busy), .load_done(load_done),
        .word_count(word_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the next expected {addr, data} and last one cycle
    always @(negedge clk) begin
        if (!rst && wr_instruction) begin
            if (prev_wr) check("wr_pulse", 1, 0);
            if (exp_q.size() == 0) check("wr_unexpected", {inst_addr, data_instruction}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("wr", {inst_addr, data_instruction}, exp_q.pop_front());
        end
        prev_wr = !rst && wr_instruction;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int addr);
        exp_q.push_back({32'(addr), w});
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!load_done && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_done"}, load_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        cyc(2);
        check("rst_data", data_instruction, 0);
        check("rst_addr", inst_addr, 0);
        check("rst_ctl", {wr_instruction, busy, load_done, timeout_err, word_count}, 0);
        rst = 1'b0;
        cyc(1);
        send_byte(8'hAA);
        check("idle_busy", busy, 0);

        // halt word terminates after being written
        do_start();
        check("t1_busy", busy, 1);
        check("t1_cnt0", word_count, 0);
        send_word(32'h20010008, 0);
        cyc(1);
        send_word(HALT, 1);
        wait_done("t1");
        check("t1_cnt", word_count, 2);
        check("t1_idle", busy, 0);
        check("t1_addr", inst_addr, 1);
        check("t1_data", data_instruction, HALT);
        check("t1_q", exp_q.size(), 0);

        // memory full: 32 back-to-back words, then extra bytes ignored
        do_start();
        for (int i = 0; i < 32; i++) send_word(32'(i), i);
        send_byte(8'h77);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        cyc(2);
        check("t2_done", load_done, 1);
        check("t2_cnt", word_count, 32);
        check("t2_addr", inst_addr, 31);
        check("t2_q", exp_q.size(), 0);

        // inter-byte timeout discards the partial word
        do_start();
        send_byte(8'h01);
        send_byte(8'h02);
        cyc(TO - 3);
        check("t3_early", timeout_err, 0);
        cyc(8);
        check("t3_fire", timeout_err, 1);
        check("t3_busy", busy, 1);
        send_word(32'h11223344, 0);
        cyc(1);
        send_word(HALT, 1);
        wait_done("t3");
        check("t3_sticky", timeout_err, 1);
        check("t3_cnt", word_count, 2);
        check("t3_q", exp_q.size(), 0);

        // restart from DONE; byte during WRITE becomes MSB of next word
        do_start();
        check("t4_clr", timeout_err, 0);
        check("t4_addr0", inst_addr, 0);
        send_word(32'hA1B2C3D4, 0);
        send_word(32'h55667788, 1);
        cyc(1);
        send_word(HALT, 2);
        wait_done("t4");
        check("t4_cnt", word_count, 3);
        check("t4_q", exp_q.size(), 0);

        // start during RECV is ignored
        do_start();
        send_byte(8'hDE);
        send_byte(8'hAD);
        do_start();
        send_byte(8'hBE);
        exp_q.push_back({32'd0, 32'hDEADBEEF});
        send_byte(8'hEF);
        cyc(1);
        check("t5_addr", inst_addr, 1);
        send_word(HALT, 1);
        wait_done("t5");
        check("t5_cnt", word_count, 2);
        check("t5_q", exp_q.size(), 0);

        // asynchronous reset mid-load, then a fresh load from address 0
        do_start();
        send_word(32'h0BADF00D, 0);
        send_word(32'h12345678, 1);
        cyc(1);
        send_byte(8'h12);
        rst = 1'b1;
        #1;
        check("t6_rst_data", data_instruction, 0);
        check("t6_rst_addr", inst_addr, 0);
        check("t6_rst_ctl", {wr_instruction, busy, load_done, timeout_err, word_count}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1);
        check("t6_idle", {busy, load_done}, 0);
        do_start();
        check("t6_cnt0", word_count, 0);
        check("t6_addr0", inst_addr, 0);
        send_word(32'h00000099, 0);
        cyc(1);
        send_word(HALT, 1);
        wait_done("t6");
        check("t6_cnt", word_count, 2);
        check("t6_q", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
